// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and
// a constant-width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Smallest r with 2**r >= v; sizes the bit counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_magnitude.sv
// Combinational magnitude/sign split of one operand. In unsigned mode the raw
// value passes through and the sign is 0.
module seq_mult_magnitude #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_value,
    input  logic         i_is_signed,
    output logic [W-1:0] o_mag,
    output logic         o_sign
);

    // The most-negative value negates onto itself, which read as unsigned is
    // exactly its magnitude.
    assign o_sign = i_is_signed & i_value[W-1];
    assign o_mag  = o_sign ? (-i_value) : i_value;

endmodule

// File: rtl/seq_mult_shift_right_p.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with
// valid/ready input and output handshakes and a pass-through tag.
module seq_mult_shift_right_p
    import seq_mult_pkg::*;
#(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int TAG_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_signed,
    input  logic [A_WIDTH-1:0]           op_a,
    input  logic [B_WIDTH-1:0]           op_b,
    input  logic [TAG_WIDTH-1:0]         in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [A_WIDTH+B_WIDTH-1:0]   product,
    output logic [TAG_WIDTH-1:0]         out_tag,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    localparam int CNT_W = clog2(A_WIDTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high and clear is low; valid/payload are held until that edge.
    state_t                       r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic [B_WIDTH:0]             r_p;
    logic [A_WIDTH-1:0]           r_a;
    logic [B_WIDTH-1:0]           r_b;
    logic                         r_neg;
    logic [TAG_WIDTH-1:0]         r_tag;
    logic [A_WIDTH+B_WIDTH-1:0]   r_product;
    logic [TAG_WIDTH-1:0]         r_out_tag;

    logic [A_WIDTH-1:0]           w_mag_a;
    logic [B_WIDTH-1:0]           w_mag_b;
    logic                         w_sign_a;
    logic                         w_sign_b;
    logic [B_WIDTH+1:0]           w_sum;
    logic [B_WIDTH:0]             w_next_p;
    logic [A_WIDTH-1:0]           w_next_a;
    logic [A_WIDTH+B_WIDTH-1:0]   w_prod_mag;
    logic [A_WIDTH+B_WIDTH-1:0]   w_prod;

    seq_mult_magnitude #(.W(A_WIDTH)) u_mag_a (
        .i_value     (op_a),
        .i_is_signed (in_signed),
        .o_mag       (w_mag_a),
        .o_sign      (w_sign_a)
    );

    seq_mult_magnitude #(.W(B_WIDTH)) u_mag_b (
        .i_value     (op_b),
        .i_is_signed (in_signed),
        .o_mag       (w_mag_b),
        .o_sign      (w_sign_b)
    );

    // One shift-add step: the adder carry lands in P's MSB, P's LSB moves into A.
    assign w_sum      = {1'b0, r_p} + (r_a[0] ? {2'b00, r_b} : '0);
    assign w_next_p   = w_sum[B_WIDTH+1:1];
    assign w_next_a   = {w_sum[0], r_a[A_WIDTH-1:1]};
    assign w_prod_mag = {w_next_p[B_WIDTH-1:0], w_next_a};
    assign w_prod     = r_neg ? (-w_prod_mag) : w_prod_mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_p       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_neg     <= 1'b0;
            r_tag     <= '0;
            r_product <= '0;
            r_out_tag <= '0;
        end else if (clear) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_neg   <= w_sign_a ^ w_sign_b;
                        r_tag   <= in_tag;
                        r_p     <= '0;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_p   <= w_next_p;
                    r_a   <= w_next_a;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(A_WIDTH - 1)) begin
                        r_product <= w_prod;
                        r_out_tag <= r_tag;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == CALC);
    assign product   = r_product;
    assign out_tag   = r_out_tag;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mult_shift_right_p.sv
// Self-checking bench for seq_mult_shift_right_p: directed cases, backpressure,
// clear, reset abort and a randomized stream against an arithmetic model.
module tb_seq_mult_shift_right_p;

    localparam int A_W = 8;
    localparam int B_W = 8;
    localparam int T_W = 4;
    localparam int P_W = A_W + B_W;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [A_W-1:0]   op_a;
    logic [B_W-1:0]   op_b;
    logic [T_W-1:0]   in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   product;
    logic [T_W-1:0]   out_tag;
    logic             busy;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [P_W-1:0]   exp_q[$];
    logic [T_W-1:0]   tag_q[$];

    seq_mult_shift_right_p #(
        .A_WIDTH(A_W), .B_WIDTH(B_W), .TAG_WIDTH(T_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .out_tag   (out_tag),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: plain integer multiply of the operands as interpreted by mode.
    function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b,
                                               input logic s);
        longint x;
        longint y;
        longint p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[P_W-1:0];
    endfunction

    // Accept at the next edge; returns with the acceptance edge just passed.
    task automatic accept(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic s, input logic [T_W-1:0] tag);
        @(negedge clk);
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1; in_signed = s; op_a = a; op_b = b; in_tag = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = A_W'($urandom); op_b = B_W'($urandom); in_signed = ~s;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_txn(input string name, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                           input logic s, input logic [T_W-1:0] tag, input logic [P_W-1:0] exp);
        int lat;
        accept(a, b, s, tag);
        check({name, "_busy"}, busy, 1);
        wait_out(lat);
        check({name, "_latency"}, lat, A_W);
        check({name, "_product"}, product, exp);
        check({name, "_tag"}, out_tag, tag);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check({name, "_idle_ready"}, in_ready, 1);
        check({name, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        int lat;
        int rises;
        int sent;
        int got;
        int cyc;
        logic [A_W-1:0] ra;
        logic [B_W-1:0] rb;
        logic           rs;
        logic [T_W-1:0] rt;
        logic [P_W-1:0] held_p;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        op_a = '0; op_b = '0; in_tag = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk); rst_n = 1'b1;

        run_txn("u13x11", 8'd13, 8'd11, 1'b0, 4'd3, 16'd143);
        run_txn("s_m3x5", 8'hFD, 8'h05, 1'b1, 4'd5, 16'hFFF1);
        run_txn("s_min_min", 8'h80, 8'h80, 1'b1, 4'd9, 16'h4000);
        run_txn("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 4'd12, 16'hFE01);
        run_txn("zero", 8'h00, 8'hA5, 1'b0, 4'd1, 16'h0000);
        run_txn("s_min_max", 8'h80, 8'h7F, 1'b1, 4'd2, 16'hC080);

        // Backpressure: hold DONE for 5 cycles while offering a new input.
        accept(8'd6, 8'd7, 1'b0, 4'd10);
        wait_out(lat);
        check("bp_latency", lat, A_W);
        in_valid = 1'b1; op_a = 8'd99; op_b = 8'd99; in_tag = 4'd15;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_product", product, 16'd42);
            check("bp_tag", out_tag, 4'd10);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        check("bp_no_ghost_txn", busy, 0);

        // Clear at CALC step 4: three steps done, fourth edge carries clear.
        held_p = product;
        accept(8'd200, 8'd3, 1'b0, 4'd7);
        repeat (3) @(posedge clk);
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        check("clr_idle_ready", in_ready, 1);
        check("clr_busy", busy, 0);
        check("clr_product_held", product, held_p);
        rises = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) rises++;
        end
        check("clr_no_out_valid", rises, 0);
        run_txn("after_clr", 8'd7, 8'd9, 1'b0, 4'd4, 16'd63);

        // Reset pulse mid-CALC.
        accept(8'd55, 8'd66, 1'b0, 4'd8);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_product", product, 0);
        check("mid_rst_out_tag", out_tag, 0);
        check("mid_rst_state", dbg_state, 0);
        @(negedge clk); rst_n = 1'b1;

        // Randomized stream: issue whenever in_ready, consume with random out_ready.
        sent = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    check("stream_product", product, exp_q.pop_front());
                    check("stream_tag", out_tag, tag_q.pop_front());
                end else begin
                    check("stream_unexpected_out", 1, 0);
                end
                got++;
            end
            if (in_ready && sent < 20) begin
                ra = A_W'($urandom); rb = B_W'($urandom);
                rs = 1'($urandom_range(0, 1)); rt = T_W'($urandom);
                in_valid = 1'b1; op_a = ra; op_b = rb; in_signed = rs; in_tag = rt;
                exp_q.push_back(ref_mul(ra, rb, rs));
                tag_q.push_back(rt);
                sent++;
            end else begin
                in_valid = 1'b0;
                op_a = A_W'($urandom); op_b = B_W'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_count", got, 20);
        check("stream_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_shift_right_p.md
# seq_mult_shift_right_p

Parametrised sequential shift-add multiplier with right-shift accumulation. It processes one multiplier bit per clock. It accepts operands through a valid/ready input handshake and returns the product, with a transaction tag, through a valid/ready output handshake that supports backpressure. Unsigned or two's-complement mode is selected per transaction. The block serves as the generic multiply engine for datapaths needing area-cheap multiplication at arbitrary operand widths.

## Interface
- A_WIDTH, 8: multiplier (op_a) width; sets iteration count; ≥2.
- B_WIDTH, 8: multiplicand (op_b) width; ≥2.
- TAG_WIDTH, 4: width of the opaque tag carried from input to output; ≥1.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; returns to IDLE, discards any in-flight or held result.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_signed  input  1  1 = both operands two's complement, 0 = unsigned.
- op_a  input  A_WIDTH  multiplier.
- op_b  input  B_WIDTH  multiplicand.
- in_tag  input  TAG_WIDTH  transaction tag.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  A_WIDTH+B_WIDTH  result, signed or unsigned per in_signed.
- out_tag  output  TAG_WIDTH  tag of the returned transaction.
- busy  output  1  high in CALC.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch tag and mode;
  - latch |op_a| into A and |op_b| into B; magnitudes are used only when in_signed=1, raw values otherwise;
  - latch the negate flag = sign(op_a) XOR sign(op_b) when signed, else 0;
  - clear P (B_WIDTH+1 bits) and the bit counter; go to CALC.
- CALC, one edge per bit:
  - sum = P + (A[0] ? B : 0);
  - {P, A} <= {sum, A} >> 1, with the sum carry entering P's MSB;
  - counter++.
  - After the A_WIDTH-th step: product <= negate ? −{P,A} : {P,A}, truncated to A_WIDTH+B_WIDTH; go to DONE.
- DONE: out_valid=1; product and out_tag held stable. On out_ready go to IDLE.
- in_ready=0 outside IDLE. No overlap of transactions.
- Width rules:
  - Magnitude of the most-negative value fits in the unsigned operand width.
  - The full product always fits in A_WIDTH+B_WIDTH bits, including (−2^(A−1))·(−2^(B−1)).
- clear, any state: next state IDLE; out_valid=0; product/out_tag keep their last value.
- clear takes priority over a same-cycle input or output handshake; that handshake does not complete.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, product=0, out_tag=0, state=IDLE.
- rst_n asserted mid-operation aborts immediately; the result is lost.
- Acceptance edge E0 → busy high from E0 to E0+A_WIDTH.
- out_valid rises after edge E0+A_WIDTH: latency A_WIDTH cycles.
- Minimum initiation interval: A_WIDTH+2 cycles, with out_ready held high.
- The output handshake at edge Ek returns to IDLE; in_ready is high in the following cycle.
- Operand inputs are sampled only at the acceptance edge. Changes during CALC are ignored.

## Structure
- Package seq_mult_pkg:
  - state encoding: IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - counter-width function clog2(A_WIDTH+1).
- Sub-module seq_mult_magnitude: combinational, parameter W. Takes value and is_signed; returns the W-bit magnitude and the sign bit. It is instantiated twice, for op_a and op_b.
- The top holds the FSM, counter, P/A/B registers, negate flag and output registers.

## Test plan
- Unsigned, 8×8: op_a=13, op_b=11, tag=3 → product=16'd143, out_tag=3, out_valid exactly 8 cycles after acceptance.
- Signed: op_a=8'hFD (−3), op_b=8'h05 → product=16'hFFF1. Also op_a=8'h80, op_b=8'h80 → 16'h4000.
- Unsigned extreme: 8'hFF×8'hFF → 16'hFE01. Zero operand: 0×8'hA5 → 16'h0000.
- Backpressure: out_ready low for 5 cycles in DONE → product, out_tag and out_valid stable, in_ready=0, new in_valid ignored. Raise out_ready → IDLE, in_ready high next cycle.
- clear asserted at CALC step 4 → IDLE next cycle, out_valid never rises. The next transaction 7×9 yields 63.
- rst_n pulsed mid-CALC → all outputs at reset values; a back-to-back stream of 20 random signed/unsigned pairs afterwards matches the reference model.
